// File: rtl/ex_mem_pkg.sv
// Shared constants and FSM encoding for the EX/MEM boundary register.
// Replaces the legacy define.v macros with typed package items.
package ex_mem_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam logic [RegBus-1:0] ZeroWord = '0;
  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  typedef enum logic [1:0] {
    ExmemEmpty = 2'd0,
    ExmemOne   = 2'd1,
    ExmemTwo   = 2'd2
  } exmem_state_e;

  // EX may only push when the skid slot will be free.
  function automatic logic ready_for(exmem_state_e s);
    return s != ExmemTwo;
  endfunction

endpackage

// File: rtl/ex_mem_if.sv
// EX->MEM handshake bus plus the ID-stage forwarding tap.
// ex_mem sits on the slave modport; the surrounding pipeline uses master.
interface ex_mem_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic [ADDR_W-1:0] ex_wd;
  logic              ex_wreg;
  logic [DATA_W-1:0] ex_wdata;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_wd;
  logic              mem_wreg;
  logic [DATA_W-1:0] mem_wdata;
  logic              fwd_we;
  logic [ADDR_W-1:0] fwd_waddr;
  logic [DATA_W-1:0] fwd_wdata;

  modport slave (
    input  ex_valid, ex_wd, ex_wreg, ex_wdata, mem_ready,
    output ex_ready, mem_valid, mem_wd, mem_wreg, mem_wdata, fwd_we, fwd_waddr, fwd_wdata
  );

  modport master (
    output ex_valid, ex_wd, ex_wreg, ex_wdata, mem_ready,
    input  ex_ready, mem_valid, mem_wd, mem_wreg, mem_wdata, fwd_we, fwd_waddr, fwd_wdata
  );
endinterface

// File: rtl/ex_mem_pipe_slot.sv
// One pipeline entry (valid, wd, wreg, wdata) with load and clear controls.
// Clear beats load so a flushed entry never survives; all fields read zero when empty.
module ex_mem_pipe_slot
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_wd,
  input  logic              in_wreg,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              valid,
  output logic [ADDR_W-1:0] wd,
  output logic              wreg,
  output logic [DATA_W-1:0] wdata
);

  logic              valid_q;
  logic [ADDR_W-1:0] wd_q;
  logic              wreg_q;
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable || clear) begin
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= 1'b0;
      wdata_q <= '0;
    end else if (load) begin
      valid_q <= in_valid;
      wd_q    <= in_wd;
      wreg_q  <= in_wreg;
      wdata_q <= in_wdata;
    end
  end

  assign valid = valid_q;
  assign wd    = wd_q;
  assign wreg  = wreg_q;
  assign wdata = wdata_q;

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with a two-entry skid buffer and synchronous flush.
// Define EX_MEM_FWD_EN to drive the fwd_* bypass tap from the main slot.
module ex_mem
  import ex_mem_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus
) (
  input logic     clk,
  input logic     rst,
  input logic     flush,
  ex_mem_if.slave bus
);

  exmem_state_e state_q, state_d;
  logic         ex_ready_q, ex_ready_d;
  logic         accept, pop;

  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;

  logic              main_valid, skid_valid;
  logic [ADDR_W-1:0] main_wd, skid_wd;
  logic              main_wreg, skid_wreg;
  logic [DATA_W-1:0] main_wdata, skid_wdata;

  assign accept = bus.ex_valid & ex_ready_q;
  assign pop    = main_valid & bus.mem_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_d    = ExmemEmpty;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        ExmemEmpty: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = ExmemOne;
          end
        end
        ExmemOne: begin
          if (accept && !pop) begin
            skid_load = 1'b1;
            state_d   = ExmemTwo;
          end else if (accept && pop) begin
            main_load = 1'b1;
          end else if (pop) begin
            main_clear = 1'b1;
            state_d    = ExmemEmpty;
          end
        end
        ExmemTwo: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
            state_d        = ExmemOne;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          state_d    = ExmemEmpty;
        end
      endcase
    end
    ex_ready_d = ready_for(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= ExmemEmpty;
      ex_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ex_ready_q <= ex_ready_d;
    end
  end

  ex_mem_pipe_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_main (
    .clk      (clk),
    .rst      (rst),
    .load     (main_load),
    .clear    (main_clear),
    .in_valid (main_from_skid ? skid_valid : 1'b1),
    .in_wd    (main_from_skid ? skid_wd : bus.ex_wd),
    .in_wreg  (main_from_skid ? skid_wreg : bus.ex_wreg),
    .in_wdata (main_from_skid ? skid_wdata : bus.ex_wdata),
    .valid    (main_valid),
    .wd       (main_wd),
    .wreg     (main_wreg),
    .wdata    (main_wdata)
  );

  ex_mem_pipe_slot #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .clear    (skid_clear),
    .in_valid (1'b1),
    .in_wd    (bus.ex_wd),
    .in_wreg  (bus.ex_wreg),
    .in_wdata (bus.ex_wdata),
    .valid    (skid_valid),
    .wd       (skid_wd),
    .wreg     (skid_wreg),
    .wdata    (skid_wdata)
  );

  assign bus.ex_ready  = ex_ready_q;
  assign bus.mem_valid = main_valid;
  assign bus.mem_wd    = main_wd;
  assign bus.mem_wreg  = main_wreg;
  assign bus.mem_wdata = main_wdata;

`ifdef EX_MEM_FWD_EN
  // Skid entry is deliberately not forwarded; ID stalls while ex_ready is low.
  assign bus.fwd_we    = main_valid & main_wreg;
  assign bus.fwd_waddr = main_wd;
  assign bus.fwd_wdata = main_wdata;
`else
  assign bus.fwd_we    = 1'b0;
  assign bus.fwd_waddr = '0;
  assign bus.fwd_wdata = DATA_W'(ZeroWord);
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for ex_mem: reset, streaming, back-pressure,
// simultaneous push/pop, flush, reset-over-flush and the forwarding tap.
module tb_ex_mem;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [38:0] obs;
  logic [38:0] exp_v;

  always #5 clk = ~clk;

  ex_mem_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  ex_mem #(
    .DATA_W (32),
    .ADDR_W (5)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  task automatic drive(input logic v, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic mr);
    bus.ex_valid  = v;
    bus.ex_wd     = wd;
    bus.ex_wreg   = wreg;
    bus.ex_wdata  = wdata;
    bus.mem_ready = mr;
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 5'd7, 1'b1, 32'hAAAA5555, 1'b1);
    step();
    step();
    obs = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    n_checks++;
    if (obs !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_mem: got %h want %h", obs, 39'd0);
    end
    n_checks++;
    if (bus.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b want 1", bus.ex_ready);
    end
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    step();
    obs = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    n_checks++;
    if (obs !== 39'd0) begin
      n_fail++;
      $display("FAIL reset_release_mem: got %h want %h", obs, 39'd0);
    end
    n_checks++;
    if (bus.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b want 1", bus.ex_ready);
    end
  endtask

  task automatic test_streaming();
    logic [4:0]  wd;
    logic [31:0] wdata;
    for (int i = 1; i <= 4; i++) begin
      wd    = 5'(i);
      wdata = 32'h11111111 * 32'(i);
      drive(1'b1, wd, wd[0], wdata, 1'b1);
      step();
      obs   = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
      exp_v = {1'b1, wd, wd[0], wdata};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL stream_entry%0d: got %h want %h", i, obs, exp_v);
      end
      n_checks++;
      if (bus.ex_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_ready%0d: got %b want 1", i, bus.ex_ready);
      end
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    step();
    obs = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    n_checks++;
    if (obs !== 39'd0) begin
      n_fail++;
      $display("FAIL stream_drain: got %h want %h", obs, 39'd0);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 5'd5, 1'b1, 32'h00000505, 1'b0);
    step();
    drive(1'b1, 5'd6, 1'b1, 32'h00000606, 1'b0);
    step();
    n_checks++;
    if (bus.ex_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full_ready: got %b want 0", bus.ex_ready);
    end
    drive(1'b1, 5'd7, 1'b1, 32'h00000707, 1'b0);
    step();
    obs   = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    exp_v = {1'b1, 5'd5, 1'b1, 32'h00000505};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL bp_hold5: got %h want %h", obs, exp_v);
    end
    n_checks++;
    if (bus.ex_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_hold_ready: got %b want 0", bus.ex_ready);
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    step();
    obs   = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    exp_v = {1'b1, 5'd6, 1'b1, 32'h00000606};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL bp_out6: got %h want %h", obs, exp_v);
    end
    n_checks++;
    if (bus.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_back: got %b want 1", bus.ex_ready);
    end
    drive(1'b1, 5'd7, 1'b1, 32'h00000707, 1'b1);
    step();
    obs   = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    exp_v = {1'b1, 5'd7, 1'b1, 32'h00000707};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL bp_out7: got %h want %h", obs, exp_v);
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    step();
    obs = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    n_checks++;
    if (obs !== 39'd0) begin
      n_fail++;
      $display("FAIL bp_drain: got %h want %h", obs, 39'd0);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd3, 1'b1, 32'h33333333, 1'b0);
    step();
    obs   = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    exp_v = {1'b1, 5'd3, 1'b1, 32'h33333333};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_hold3: got %h want %h", obs, exp_v);
    end
    drive(1'b1, 5'd9, 1'b0, 32'h99999999, 1'b1);
    step();
    obs   = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    exp_v = {1'b1, 5'd9, 1'b0, 32'h99999999};
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL b2b_out9: got %h want %h", obs, exp_v);
    end
    n_checks++;
    if (bus.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b want 1", bus.ex_ready);
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    step();
    obs = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    n_checks++;
    if (obs !== 39'd0) begin
      n_fail++;
      $display("FAIL b2b_drain: got %h want %h", obs, 39'd0);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd10, 1'b1, 32'h0A0A0A0A, 1'b0);
    step();
    drive(1'b1, 5'd11, 1'b1, 32'h0B0B0B0B, 1'b0);
    step();
    flush = 1'b1;
    drive(1'b1, 5'd12, 1'b1, 32'h0C0C0C0C, 1'b1);
    step();
    flush = 1'b0;
    obs = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    n_checks++;
    if (obs !== 39'd0) begin
      n_fail++;
      $display("FAIL flush_mem: got %h want %h", obs, 39'd0);
    end
    n_checks++;
    if (bus.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: got %b want 1", bus.ex_ready);
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    step();
    obs = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    n_checks++;
    if (obs !== 39'd0) begin
      n_fail++;
      $display("FAIL flush_no12: got %h want %h", obs, 39'd0);
    end
    // Reset coinciding with flush while full.
    drive(1'b1, 5'd13, 1'b1, 32'h0D0D0D0D, 1'b0);
    step();
    drive(1'b1, 5'd14, 1'b1, 32'h0E0E0E0E, 1'b0);
    step();
    rst   = 1'b0;
    flush = 1'b1;
    drive(1'b1, 5'd15, 1'b1, 32'h0F0F0F0F, 1'b1);
    step();
    obs = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    n_checks++;
    if (obs !== 39'd0) begin
      n_fail++;
      $display("FAIL rstflush_mem: got %h want %h", obs, 39'd0);
    end
    n_checks++;
    if (bus.ex_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstflush_ready: got %b want 1", bus.ex_ready);
    end
    rst   = 1'b1;
    flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    step();
    obs = {bus.mem_valid, bus.mem_wd, bus.mem_wreg, bus.mem_wdata};
    n_checks++;
    if (obs !== 39'd0) begin
      n_fail++;
      $display("FAIL rstflush_after: got %h want %h", obs, 39'd0);
    end
  endtask

  task automatic test_forwarding();
    logic [37:0] fobs;
    logic [37:0] fexp;
    drive(1'b1, 5'd8, 1'b1, 32'hDEADBEEF, 1'b0);
    step();
    fobs = {bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata};
`ifdef EX_MEM_FWD_EN
    fexp = {1'b1, 5'd8, 32'hDEADBEEF};
`else
    fexp = '0;
`endif
    n_checks++;
    if (fobs !== fexp) begin
      n_fail++;
      $display("FAIL fwd_wreg1: got %h want %h", fobs, fexp);
    end
    drive(1'b1, 5'd8, 1'b0, 32'hDEADBEEF, 1'b1);
    step();
    fobs = {bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata};
`ifdef EX_MEM_FWD_EN
    fexp = {1'b0, 5'd8, 32'hDEADBEEF};
`else
    fexp = '0;
`endif
    n_checks++;
    if (fobs !== fexp) begin
      n_fail++;
      $display("FAIL fwd_wreg0: got %h want %h", fobs, fexp);
    end
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b1);
    step();
    fobs = {bus.fwd_we, bus.fwd_waddr, bus.fwd_wdata};
    n_checks++;
    if (fobs !== 38'd0) begin
      n_fail++;
      $display("FAIL fwd_empty: got %h want %h", fobs, 38'd0);
    end
  endtask

  initial begin
    drive(1'b0, 5'd0, 1'b0, 32'h0, 1'b0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_forwarding();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
Name: ex_mem

Overview:
- EX/MEM pipeline boundary register between the execute stage and the memory-access stage of the 5-stage MIPS32 core.
- Captures the execute result (destination address, write enable, write data) and presents it to MEM one cycle later.
- Uses a valid/ready handshake with a two-entry skid buffer, so a MEM back-pressure stall does not combinationally reach EX.
- Supports synchronous flush for exceptions and branch recovery.

Parameters:
- DATA_W, 32, width of write data; equals `RegBus.
- ADDR_W, 5, width of register address; equals `RegAddrBus.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 resets)
- flush  input  1  discard all held entries
- ex_valid  input  1  EX presents a result
- ex_ready  output  1  ex_mem can accept; registered
- ex_wd  input  ADDR_W  destination register from EX
- ex_wreg  input  1  write-enable from EX
- ex_wdata  input  DATA_W  result from EX
- mem_valid  output  1  entry presented to MEM
- mem_ready  input  1  MEM consumes the presented entry
- mem_wd  output  ADDR_W  destination register to MEM
- mem_wreg  output  1  write-enable to MEM
- mem_wdata  output  DATA_W  data to MEM
- fwd_we  output  1  forwarding write-enable (see Optional Feature)
- fwd_waddr  output  ADDR_W  forwarding address
- fwd_wdata  output  DATA_W  forwarding data

Behaviour:
- Reset (rst==0 at clk edge):
  - State EMPTY.
  - mem_valid=0, mem_wd=0, mem_wreg=0, mem_wdata=`ZeroWord.
  - Skid entry cleared; ex_ready=1.
  - Inputs are ignored in the reset cycle. Reset mid-transfer drops all held entries.
- Handshakes:
  - Accept = ex_valid & ex_ready.
  - Pop = mem_valid & mem_ready.
  - Both are evaluated at the same clk edge.
- FSM states are EMPTY, ONE (main slot only) and TWO (main + skid).
- EMPTY:
  - Accept -> load main, mem_valid=1, go to ONE.
  - Otherwise stay.
- ONE:
  - Accept & !pop -> load skid, go to TWO, ex_ready=0 next cycle.
  - Accept & pop -> main replaced with new input, stay ONE.
  - !accept & pop -> clear main fields to zero, mem_valid=0, go to EMPTY.
- TWO:
  - ex_ready=0, so no accept is possible.
  - Pop -> main<=skid, skid cleared, ex_ready=1, go to ONE.
  - Otherwise hold.
- Ordering is strictly FIFO; no entry is duplicated or lost except on flush or reset.
- Latency: an accepted entry appears on the mem_* outputs the cycle after acceptance when MEM is not stalled.
- The mem_* fields are always zero whenever mem_valid=0.
- ex_ready is a pure register: ex_ready = !(next state is TWO).
- Flush has priority over accept and pop in the same cycle:
  - Go to EMPTY and clear all fields.
  - ex_ready=1 next cycle.
  - A same-cycle input is dropped.
- Rst has priority over flush.
- Data passes through unmodified: no width conversion, no arithmetic.

Optional Feature:
- Macro: EX_MEM_FWD_EN.
- Defined:
  - fwd_we = mem_valid & mem_wreg, fwd_waddr = mem_wd, fwd_wdata = mem_wdata.
  - All combinational from the main slot, for ID-stage bypass of RAW hazards.
  - The skid entry is not forwarded; ID must stall when ex_ready=0.
- Undefined: fwd_we=0, fwd_waddr=0, fwd_wdata=`ZeroWord constantly.
- The ports exist in both builds.

Decomposition:
- Shared define.v holds:
  - `RegBus, `RegAddrBus, `ZeroWord.
  - `RstEnable=1'b0 and `RstDisable=1'b1.
  - FSM encodings `EXMEM_EMPTY=2'd0, `EXMEM_ONE=2'd1, `EXMEM_TWO=2'd2.
- One natural sub-module, pipe_slot:
  - A single valid+wd+wreg+wdata register with load/clear controls.
  - Instantiated twice (main, skid).
- FSM and handshake logic stay in ex_mem.

Test Plan:
- Reset: hold rst=0 two cycles with ex_valid=1 -> mem_valid=0, all mem_* =0, ex_ready=1 after release.
- Streaming: ex_valid=1 for 4 cycles with wd=1..4, wdata=0x11111111..0x44444444, mem_ready=1 -> each appears one cycle later in order, mem_wreg follows ex_wreg, ex_ready stays 1.
- Back-pressure:
  - Setup: mem_ready=0 while pushing wd=5 then wd=6.
  - Expected: state TWO, ex_ready=0, a third offered entry (wd=7) is not accepted.
  - Then mem_ready=1: outputs wd=5 then wd=6, then wd=7 once re-offered.
- Simultaneous push/pop in ONE: wd=3 held, mem_ready=1 and ex_valid=1 with wd=9 in the same cycle -> next cycle mem_wd=9, mem_valid=1, no bubble.
- Flush:
  - Setup: state TWO, then flush=1 with ex_valid=1 (wd=12).
  - Expected: next cycle mem_valid=0, all fields 0, ex_ready=1, wd=12 never appears.
  - Also: rst=0 coinciding with flush gives the reset values.
- Forwarding with EX_MEM_FWD_EN: entry wd=8, wreg=1, wdata=0xDEADBEEF in main -> fwd_we=1, fwd_waddr=8, fwd_wdata=0xDEADBEEF. Same entry with wreg=0 -> fwd_we=0. Without the macro, fwd_* are always 0.
